// File: rtl/rect_object_bank.sv
// rtl/rect_object_bank.sv - N_OBJ run-time rectangles with frame-synchronous attributes, outline, blink and fixed priority
module rect_object_bank #(
    parameter int                N_OBJ                = 4,
    parameter int                COORD_W              = 11,
    parameter int                BORDER_W             = 2,
    parameter int                BLINK_FRAMES         = 30,
    parameter logic [7:0]        TRANSPARENT_ENCODING = 8'hFF,
    localparam int               IDX_W                = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [COORD_W-1:0]         pixelX,
    input  logic [COORD_W-1:0]         pixelY,
    input  logic [N_OBJ*COORD_W-1:0]   objTopLeftX,
    input  logic [N_OBJ*COORD_W-1:0]   objTopLeftY,
    input  logic [N_OBJ*COORD_W-1:0]   objWidth,
    input  logic [N_OBJ*COORD_W-1:0]   objHeight,
    input  logic [N_OBJ*8-1:0]         objColor,
    input  logic [N_OBJ-1:0]           objEnable,
    input  logic [N_OBJ-1:0]           objOutline,
    input  logic [N_OBJ-1:0]           objBlink,
    output logic                       drawingRequest,
    output logic [7:0]                 RGBout,
    output logic [COORD_W-1:0]         offsetX,
    output logic [COORD_W-1:0]         offsetY,
    output logic [IDX_W-1:0]           hitIndex,
    output logic [N_OBJ-1:0]           hitMask
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [COORD_W:0] BW1 = (COORD_W+1)'(BORDER_W);
    localparam logic [COORD_W:0] BW2 = (COORD_W+1)'(2 * BORDER_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [N_OBJ*COORD_W-1:0] tlx_q, tly_q, w_q, h_q;
    logic [N_OBJ*8-1:0]       color_q;
    logic [N_OBJ-1:0]         en_q, outl_q, blink_q;
    logic [CNT_W-1:0]         frame_cnt_q;
    logic                     blink_phase_q;

    logic                     drawing_request_q;
    logic [7:0]               rgb_q;
    logic [COORD_W-1:0]       offset_x_q, offset_y_q;
    logic [IDX_W-1:0]         hit_index_q;
    logic [N_OBJ-1:0]         hit_mask_q;

    logic [N_OBJ-1:0]         hit;
    logic [COORD_W-1:0]       dx [N_OBJ];
    logic [COORD_W-1:0]       dy [N_OBJ];

    // Coordinates are widened by one bit so X+W never wraps; offscreen parts clip naturally.
    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        logic [COORD_W:0] x0, y0, w, h, px, py, dxe, dye;
        logic             in_x, in_y, thin, on_edge;

        assign x0  = {1'b0, tlx_q[g*COORD_W +: COORD_W]};
        assign y0  = {1'b0, tly_q[g*COORD_W +: COORD_W]};
        assign w   = {1'b0, w_q[g*COORD_W +: COORD_W]};
        assign h   = {1'b0, h_q[g*COORD_W +: COORD_W]};
        assign px  = {1'b0, pixelX};
        assign py  = {1'b0, pixelY};

        assign in_x = (px >= x0) && (px < x0 + w);
        assign in_y = (py >= y0) && (py < y0 + h);

        assign dx[g] = pixelX - tlx_q[g*COORD_W +: COORD_W];
        assign dy[g] = pixelY - tly_q[g*COORD_W +: COORD_W];
        assign dxe   = {1'b0, dx[g]};
        assign dye   = {1'b0, dy[g]};

        // Rectangles too small to have a hollow centre are drawn solid.
        assign thin    = (w <= BW2) || (h <= BW2);
        assign on_edge = (dxe < BW1) || (dxe >= w - BW1) || (dye < BW1) || (dye >= h - BW1);

        assign hit[g] = en_q[g] && in_x && in_y && (!outl_q[g] || thin || on_edge)
                        && (!blink_q[g] || blink_phase_q);
    end

    logic                found;
    logic [IDX_W-1:0]    win_idx;
    logic [COORD_W-1:0]  win_dx, win_dy;
    logic [7:0]          win_col;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_dx  = '0;
        win_dy  = '0;
        win_col = TRANSPARENT_ENCODING;
        for (int i = 0; i < N_OBJ; i++) begin
            if (hit[i] && !found) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
                win_dx  = dx[i];
                win_dy  = dy[i];
                win_col = color_q[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            tlx_q         <= '0;
            tly_q         <= '0;
            w_q           <= '0;
            h_q           <= '0;
            color_q       <= '0;
            en_q          <= '0;
            outl_q        <= '0;
            blink_q       <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (startOfFrame) begin
            tlx_q   <= objTopLeftX;
            tly_q   <= objTopLeftY;
            w_q     <= objWidth;
            h_q     <= objHeight;
            color_q <= objColor;
            en_q    <= objEnable;
            outl_q  <= objOutline;
            blink_q <= objBlink;
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            drawing_request_q <= 1'b0;
            rgb_q             <= TRANSPARENT_ENCODING;
            offset_x_q        <= '0;
            offset_y_q        <= '0;
            hit_index_q       <= '0;
            hit_mask_q        <= '0;
        end else begin
            drawing_request_q <= found;
            rgb_q             <= win_col;
            offset_x_q        <= win_dx;
            offset_y_q        <= win_dy;
            hit_index_q       <= win_idx;
            hit_mask_q        <= hit;
        end
    end

    assign drawingRequest = drawing_request_q;
    assign RGBout         = rgb_q;
    assign offsetX        = offset_x_q;
    assign offsetY        = offset_y_q;
    assign hitIndex       = hit_index_q;
    assign hitMask        = hit_mask_q;

endmodule

// File: tb/tb_rect_object_bank.sv
// tb/tb_rect_object_bank.sv - directed table-driven bench for rect_object_bank
module tb_rect_object_bank;

    localparam int N  = 4;
    localparam int CW = 11;
    localparam int NV = 25;

    logic              clk = 1'b0;
    logic              resetN, startOfFrame;
    logic [CW-1:0]     pixelX, pixelY;
    logic [N*CW-1:0]   objTopLeftX, objTopLeftY, objWidth, objHeight;
    logic [N*8-1:0]    objColor;
    logic [N-1:0]      objEnable, objOutline, objBlink;
    logic              drawingRequest;
    logic [7:0]        RGBout;
    logic [CW-1:0]     offsetX, offsetY;
    logic [1:0]        hitIndex;
    logic [N-1:0]      hitMask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rect_object_bank #(
        .N_OBJ(N), .COORD_W(CW), .BORDER_W(2), .BLINK_FRAMES(2), .TRANSPARENT_ENCODING(8'hFF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .objTopLeftX(objTopLeftX), .objTopLeftY(objTopLeftY),
        .objWidth(objWidth), .objHeight(objHeight), .objColor(objColor),
        .objEnable(objEnable), .objOutline(objOutline), .objBlink(objBlink),
        .drawingRequest(drawingRequest), .RGBout(RGBout),
        .offsetX(offsetX), .offsetY(offsetY),
        .hitIndex(hitIndex), .hitMask(hitMask)
    );

    typedef struct {
        int         phase;
        int         px, py;
        logic       req;
        logic [7:0] rgb;
        int         ox, oy, idx;
        logic [3:0] mask;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                           input logic [7:0] col, input logic en, input logic outl, input logic blk);
        objTopLeftX[i*CW +: CW] = CW'(x);
        objTopLeftY[i*CW +: CW] = CW'(y);
        objWidth[i*CW +: CW]    = CW'(w);
        objHeight[i*CW +: CW]   = CW'(h);
        objColor[i*8 +: 8]      = col;
        objEnable[i]            = en;
        objOutline[i]           = outl;
        objBlink[i]             = blk;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        pixelX = CW'(x);
        pixelY = CW'(y);
        tick();
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [7:0] rgb,
                           input int ox, input int oy, input int idx, input logic [3:0] mask);
        chk({tag, " req"},  int'(drawingRequest), int'(req));
        chk({tag, " rgb"},  int'(RGBout), int'(rgb));
        chk({tag, " offx"}, int'(offsetX), ox);
        chk({tag, " offy"}, int'(offsetY), oy);
        chk({tag, " idx"},  int'(hitIndex), idx);
        chk({tag, " mask"}, int'(hitMask), int'(mask));
    endtask

    task automatic run_phase(input int ph);
        for (int k = 0; k < NV; k++) begin
            if (tbl[k].phase == ph) begin
                pix(tbl[k].px, tbl[k].py);
                chk_out($sformatf("vec%0d(%0d,%0d)", k, tbl[k].px, tbl[k].py),
                        tbl[k].req, tbl[k].rgb, tbl[k].ox, tbl[k].oy, tbl[k].idx, tbl[k].mask);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{2,   10,  10, 1'b1, 8'h5B,  0,  0, 0, 4'b0001};
        tbl[1]  = '{2,   29,  29, 1'b1, 8'h5B, 19, 19, 0, 4'b0001};
        tbl[2]  = '{2,   30,  10, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[3]  = '{2,    9,  10, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[4]  = '{2,   10,  29, 1'b1, 8'h5B,  0, 19, 0, 4'b0001};
        tbl[5]  = '{2,   10,  30, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[6]  = '{3,   16,  16, 1'b1, 8'h5B,  6,  6, 0, 4'b0011};
        tbl[7]  = '{3,   32,  32, 1'b1, 8'hE0, 17, 17, 1, 4'b0010};
        tbl[8]  = '{3, 2047, 102, 1'b1, 8'h33,  7,  2, 2, 4'b0100};
        tbl[9]  = '{3, 2039, 102, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[10] = '{3,  100, 100, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[11] = '{3,   34,  34, 1'b1, 8'hE0, 19, 19, 1, 4'b0010};
        tbl[12] = '{3,   35,  35, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[13] = '{4,    1,   5, 1'b1, 8'h5B,  1,  5, 0, 4'b0001};
        tbl[14] = '{4,    8,   5, 1'b1, 8'h5B,  8,  5, 0, 4'b0001};
        tbl[15] = '{4,    5,   5, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[16] = '{4,    5,   2, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[17] = '{4,    5,   1, 1'b1, 8'h5B,  5,  1, 0, 4'b0001};
        tbl[18] = '{4,    7,   5, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[19] = '{4,    9,   9, 1'b1, 8'h5B,  9,  9, 0, 4'b0001};
        tbl[20] = '{4,   10,   5, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[21] = '{5,    2,   2, 1'b1, 8'h5B,  2,  2, 0, 4'b0001};
        tbl[22] = '{5,    3,   5, 1'b1, 8'h5B,  3,  5, 0, 4'b0001};
        tbl[23] = '{5,    4,   5, 1'b0, 8'hFF,  0,  0, 0, 4'b0000};
        tbl[24] = '{5,    0,   0, 1'b1, 8'h5B,  0,  0, 0, 4'b0001};

        resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
        objTopLeftX = '0; objTopLeftY = '0; objWidth = '0; objHeight = '0;
        objColor = '0; objEnable = '0; objOutline = '0; objBlink = '0;
        set_obj(0, 10, 10, 20, 20, 8'h5B, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_out("reset", 1'b0, 8'hFF, 0, 0, 0, 4'b0000);

        // Released but no startOfFrame yet: nothing may be drawn.
        resetN = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            pix(k, k);
            chk($sformatf("preframe%0d req", k), int'(drawingRequest), 0);
            chk($sformatf("preframe%0d rgb", k), int'(RGBout), 'hFF);
        end

        frame();
        run_phase(2);

        set_obj(1, 15, 15, 20, 20, 8'hE0, 1'b1, 1'b0, 1'b0);
        set_obj(2, 2040, 100, 20, 5, 8'h33, 1'b1, 1'b0, 1'b0);
        set_obj(3, 100, 100, 0, 10, 8'h44, 1'b1, 1'b0, 1'b0);
        frame();
        run_phase(3);

        set_obj(0, 0, 0, 10, 10, 8'h5B, 1'b1, 1'b1, 1'b0);
        objEnable[3:1] = 3'b000;
        frame();
        run_phase(4);

        objWidth[0 +: CW] = CW'(4);
        frame();
        run_phase(5);

        // Blink with BLINK_FRAMES=2 starting from a fresh counter.
        resetN = 1'b0; tick(); resetN = 1'b1;
        set_obj(0, 0, 0, 10, 10, 8'h11, 1'b1, 1'b0, 1'b1);
        set_obj(1, 20, 0, 10, 10, 8'h22, 1'b1, 1'b0, 1'b0);
        for (int p = 1; p <= 4; p++) begin
            frame();
            pix(5, 5);
            chk($sformatf("blink%0d obj0 req", p), int'(drawingRequest), (p == 1 || p == 4) ? 1 : 0);
            pix(25, 5);
            chk_out($sformatf("blink%0d obj1", p), 1'b1, 8'h22, 5, 5, 1, 4'b0010);
        end

        // Mid-frame attribute change is ignored until the next frame.
        objTopLeftX[1*CW +: CW] = CW'(40);
        pix(25, 5);
        chk_out("midframe old", 1'b1, 8'h22, 5, 5, 1, 4'b0010);
        pix(45, 5);
        chk_out("midframe new", 1'b0, 8'hFF, 0, 0, 0, 4'b0000);
        pixelX = CW'(25); pixelY = CW'(5);
        frame();
        chk_out("sof cycle old set", 1'b1, 8'h22, 5, 5, 1, 4'b0010);
        pix(25, 5);
        chk_out("after sof old pos", 1'b0, 8'hFF, 0, 0, 0, 4'b0000);
        pix(45, 5);
        chk_out("after sof new pos", 1'b1, 8'h22, 5, 5, 1, 4'b0010);

        // One-cycle reset mid-frame blanks until the next startOfFrame.
        resetN = 1'b0;
        pix(45, 5);
        chk_out("midreset", 1'b0, 8'hFF, 0, 0, 0, 4'b0000);
        resetN = 1'b1;
        pix(45, 5);
        chk_out("post reset", 1'b0, 8'hFF, 0, 0, 0, 4'b0000);
        pix(45, 5);
        chk_out("post reset2", 1'b0, 8'hFF, 0, 0, 0, 4'b0000);
        frame();
        pix(45, 5);
        chk_out("relatched", 1'b1, 8'h22, 5, 5, 1, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
